// File: rtl/mem_arb_proxy.sv
// Round-robin N-port memory proxy: each stage's request is issued downstream exactly once
// and its response/rdata is held until that stage's pipe_load.
module mem_arb_proxy #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_PORTS-1:0]              port_read,
    input  logic [NUM_PORTS-1:0]              port_write,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]   port_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]   port_wdata,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0] port_wmask,
    input  logic [NUM_PORTS-1:0]              pipe_load,
    output logic [NUM_PORTS-1:0]              port_resp,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]   port_rdata,
    output logic                              mem_read,
    output logic                              mem_write,
    output logic [ADDR_WIDTH-1:0]             mem_address,
    output logic [DATA_WIDTH-1:0]             mem_wdata,
    output logic [DATA_WIDTH/8-1:0]           mem_byte_enable,
    input  logic                              mem_resp,
    input  logic [DATA_WIDTH-1:0]             mem_rdata
);

    localparam int BW = DATA_WIDTH / 8;
    localparam int GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          grant_q, grant_d;
    logic [GW-1:0]          rr_q, rr_d;
    logic [NUM_PORTS-1:0]   done_q, done_d;
    logic [DATA_WIDTH-1:0]  stored_q [NUM_PORTS];
    logic [NUM_PORTS-1:0]   pending;
    logic [GW-1:0]          pick;
    logic                   found;
    logic                   hit;

    // A completed access stays masked until its stage advances.
    assign pending = (port_read | port_write) & ~done_q;
    assign hit     = (state_q == BUSY) && mem_resp;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        pick  = rr_q;
        found = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!found && pending[(int'(rr_q) + k) % NUM_PORTS]) begin
                found = 1'b1;
                pick  = GW'((int'(rr_q) + k) % NUM_PORTS);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        done_d  = done_q & ~pipe_load;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    // pipe_load in the response cycle means the stage consumes the data live.
                    if (!pipe_load[grant_q]) done_d[grant_q] = 1'b1;
                    rr_d    = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_comb begin
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        if (state_q == BUSY) begin
            mem_write       = port_write[grant_q];
            mem_read        = port_read[grant_q] & ~port_write[grant_q];
            mem_address     = port_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata       = port_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
            mem_byte_enable = port_wmask[grant_q*BW +: BW];
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_PORTS; i++) begin
            port_resp[i] = done_q[i] | (hit && grant_q == GW'(i));
            port_rdata[i*DATA_WIDTH +: DATA_WIDTH] = (hit && grant_q == GW'(i)) ? mem_rdata : stored_q[i];
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            rr_q    <= '0;
            done_q  <= '0;
            // NOTE: the small rdata store is reset because port_rdata exposes it directly after reset.
            for (int i = 0; i < NUM_PORTS; i++) stored_q[i] <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            done_q  <= done_d;
            if (hit) stored_q[grant_q] <= mem_rdata;
        end
    end

    // A granted stage must hold its request until the downstream response arrives.
    assert property (@(posedge clk) disable iff (rst)
        (state_q == BUSY) |-> (port_read[grant_q] | port_write[grant_q]));

endmodule

// File: tb/tb_mem_arb_proxy.sv
// Self-checking bench for mem_arb_proxy: directed scenarios plus randomized stages and memory,
// all checked every cycle against a transaction-level model of the arbiter.
module tb_mem_arb_proxy;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int BW = DW / 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    port_read, port_write, pipe_load, port_resp;
    logic [N*AW-1:0] port_addr;
    logic [N*DW-1:0] port_wdata, port_rdata;
    logic [N*BW-1:0] port_wmask;
    logic            mem_read, mem_write, mem_resp;
    logic [AW-1:0]   mem_address;
    logic [DW-1:0]   mem_wdata, mem_rdata;
    logic [BW-1:0]   mem_byte_enable;

    mem_arb_proxy #(.NUM_PORTS(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .port_read(port_read), .port_write(port_write), .port_addr(port_addr),
        .port_wdata(port_wdata), .port_wmask(port_wmask), .pipe_load(pipe_load),
        .port_resp(port_resp), .port_rdata(port_rdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_byte_enable(mem_byte_enable),
        .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level model: which stage is being served, who has completed, who is next in line.
    bit           m_synced = 1'b0;
    bit           m_busy;
    int           m_grant, m_rr, m_age;
    bit [N-1:0]   m_done;
    logic [DW-1:0] m_stored [N];
    int           cyc = 0;
    int           grant_log[$];
    int           grant_cyc[$];
    int           adv_cnt[N];
    int           seen[N];

    always @(negedge clk) begin : model
        logic [N-1:0]    exp_resp;
        logic [N*DW-1:0] exp_rdata;
        bit              served;
        bit [N-1:0]      want;
        int              cand;
        cyc++;
        served = m_busy && mem_resp;
        if (m_synced) begin
            for (int i = 0; i < N; i++) begin
                exp_resp[i] = m_done[i] || (served && m_grant == i);
                exp_rdata[i*DW +: DW] = (served && m_grant == i) ? mem_rdata : m_stored[i];
            end
            check("mem_read", mem_read, m_busy && port_read[m_grant] && !port_write[m_grant]);
            check("mem_write", mem_write, m_busy && port_write[m_grant]);
            if (m_busy) begin
                check("mem_address", mem_address, port_addr[m_grant*AW +: AW]);
                check("mem_wdata", mem_wdata, port_wdata[m_grant*DW +: DW]);
                check("mem_byte_enable", mem_byte_enable, port_wmask[m_grant*BW +: BW]);
            end
            check("port_resp", port_resp, exp_resp);
            check("port_rdata", port_rdata, exp_rdata);
            if (!rst)
                for (int i = 0; i < N; i++)
                    if (pipe_load[i] && exp_resp[i]) adv_cnt[i]++;
        end
        if (rst) begin
            m_synced = 1'b1;
            m_busy   = 1'b0;
            m_grant  = 0;
            m_rr     = 0;
            m_age    = 0;
            m_done   = '0;
            for (int i = 0; i < N; i++) m_stored[i] = '0;
        end else if (m_synced) begin
            want   = (port_read | port_write) & ~m_done;
            m_done = m_done & ~pipe_load;
            if (m_busy) begin
                if (mem_resp) begin
                    m_stored[m_grant] = mem_rdata;
                    if (!pipe_load[m_grant]) m_done[m_grant] = 1'b1;
                    m_rr   = (m_grant + 1) % N;
                    m_busy = 1'b0;
                end else begin
                    m_age++;
                end
            end else begin
                for (int k = 0; k < N; k++) begin
                    cand = (m_rr + k) % N;
                    if (!m_busy && want[cand]) begin
                        m_busy  = 1'b1;
                        m_grant = cand;
                        m_age   = 0;
                        grant_log.push_back(cand);
                        grant_cyc.push_back(cyc + 1);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input bit rd, input bit wr, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [BW-1:0] m);
        port_read[i]         = rd;
        port_write[i]        = wr;
        port_addr[i*AW +: AW] = a;
        port_wdata[i*DW +: DW] = d;
        port_wmask[i*BW +: BW] = m;
    endtask

    task automatic reset_dut();
        tick();
        rst = 1'b1;
        port_read = '0;
        port_write = '0;
        pipe_load = '0;
        mem_resp = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Memory answers after lat busy cycles; optionally the served stage advances in the response cycle.
    task automatic auto_cycle(input int lat, input bit pl_on_resp);
        tick();
        mem_rdata = {$urandom, $urandom};
        mem_resp  = m_busy && (m_age >= lat - 1);
        pipe_load = '0;
        if (pl_on_resp && mem_resp) pipe_load[m_grant] = 1'b1;
    endtask

    task automatic rand_cycle();
        int op;
        tick();
        rst       = ($urandom_range(0, 599) == 0);
        mem_rdata = {$urandom, $urandom};
        mem_resp  = m_busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        for (int i = 0; i < N; i++) begin
            pipe_load[i] = 1'b0;
            if (adv_cnt[i] != seen[i]) begin
                seen[i]       = adv_cnt[i];
                port_read[i]  = 1'b0;
                port_write[i] = 1'b0;
            end
            if (!port_read[i] && !port_write[i] && !m_done[i] && $urandom_range(0, 2) == 0) begin
                op = $urandom_range(0, 3);
                set_port(i, op != 2, op >= 2, $urandom, {$urandom, $urandom}, BW'($urandom));
            end
            if (m_done[i] && $urandom_range(0, 2) == 0) pipe_load[i] = 1'b1;
            else if ($urandom_range(0, 19) == 0) pipe_load[i] = 1'b1;
        end
        if (m_busy && mem_resp && $urandom_range(0, 1) == 0) pipe_load[m_grant] = 1'b1;
    endtask

    initial begin
        int rd_cnt, wr_cnt, base;
        rst = 1'b1;
        port_read = '0; port_write = '0; pipe_load = '0;
        port_addr = '0; port_wdata = '0; port_wmask = '0;
        mem_resp = 1'b0; mem_rdata = '0;

        // Single read, 3-cycle memory latency, stage stalls 5 cycles.
        reset_dut();
        set_port(0, 1, 0, 32'h100, '0, '0);
        #2;
        check("reset_mem_read", mem_read, 1'b0);
        check("reset_mem_write", mem_write, 1'b0);
        check("reset_mem_address", mem_address, 32'h0);
        check("reset_port_resp", port_resp, 3'b000);
        check("reset_port_rdata", port_rdata, '0);
        rd_cnt = int'(mem_read);
        for (int c = 0; c < 3; c++) begin
            tick();
            mem_resp = (c == 2);
            if (c == 2) mem_rdata = 64'hCAFEF00D_DEADBEEF;
            #2;
            rd_cnt += int'(mem_read);
            if (c == 0) check("t1_addr", mem_address, 32'h100);
            if (c == 2) check("t1_resp_live", {port_resp[0], port_rdata[DW-1:0]}, {1'b1, 64'hCAFEF00D_DEADBEEF});
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            mem_resp  = 1'b0;
            mem_rdata = {$urandom, $urandom};
            #2;
            rd_cnt += int'(mem_read);
            check("t1_resp_held", {port_resp[0], port_rdata[DW-1:0]}, {1'b1, 64'hCAFEF00D_DEADBEEF});
        end
        check("t1_read_cycles", rd_cnt, 3);
        tick();
        pipe_load[0] = 1'b1;
        port_read[0] = 1'b0;
        tick();
        pipe_load[0] = 1'b0;
        #2;
        check("t1_resp_cleared", port_resp[0], 1'b0);

        // Write on port 1 with a 4-cycle stall: exactly one downstream burst.
        set_port(1, 0, 1, 32'h200, 64'h12345678, 8'h0F);
        wr_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            tick();
            mem_resp = (c == 1);
            #2;
            wr_cnt += int'(mem_write);
            if (c == 0) check("t3_fields", {mem_address, mem_wdata, mem_byte_enable}, {32'h200, 64'h12345678, 8'h0F});
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            mem_resp = 1'b0;
            #2;
            wr_cnt += int'(mem_write);
            check("t3_resp_held", port_resp[1], 1'b1);
        end
        check("t3_write_cycles", wr_cnt, 2);
        tick();
        pipe_load[1] = 1'b1;
        port_write[1] = 1'b0;
        tick();
        pipe_load[1] = 1'b0;
        #2;
        check("t3_resp_cleared", port_resp[1], 1'b0);

        // pipe_load in the response cycle: one-cycle resp, then a fresh request is re-arbitrated.
        set_port(0, 1, 0, 32'h100, '0, '0);
        tick();
        tick();
        mem_resp = 1'b1;
        mem_rdata = 64'h01234567_89ABCDEF;
        pipe_load[0] = 1'b1;
        #2;
        check("t4_resp_live", {port_resp[0], port_rdata[DW-1:0]}, {1'b1, 64'h01234567_89ABCDEF});
        tick();
        mem_resp = 1'b0;
        pipe_load[0] = 1'b0;
        port_addr[AW-1:0] = 32'h140;
        #2;
        check("t4_resp_dropped", {port_resp[0], mem_read}, 2'b00);
        tick();
        #2;
        check("t4_reissue", {mem_read, mem_address}, {1'b1, 32'h140});
        tick();
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        pipe_load[0] = 1'b1;
        port_read[0] = 1'b0;
        tick();
        pipe_load[0] = 1'b0;

        // Reset while busy; the late memory response must be ignored.
        set_port(0, 1, 0, 32'h180, '0, '0);
        tick();
        rst = 1'b1;
        #2;
        check("t5_busy_before_rst", mem_read, 1'b1);
        tick();
        rst = 1'b0;
        mem_resp = 1'b1;
        #2;
        check("t5_after_rst", {mem_read, mem_write, port_resp}, 5'b00000);
        tick();
        mem_resp = 1'b0;
        #2;
        check("t5_late_resp_ignored", {port_resp, mem_read}, 4'b0001);
        tick();
        mem_resp = 1'b1;
        tick();
        mem_resp = 1'b0;
        pipe_load[0] = 1'b1;
        port_read[0] = 1'b0;
        tick();
        pipe_load[0] = 1'b0;

        // Two stages pending from reset: port 0, one idle cycle, port 1; then again after both advance.
        reset_dut();
        base = grant_log.size();
        set_port(0, 1, 0, 32'h300, '0, '0);
        set_port(1, 1, 0, 32'h304, '0, '0);
        for (int c = 0; c < 40; c++) begin
            auto_cycle(2, 0);
            if (m_done[1:0] == 2'b11) break;
        end
        check("t2_count", grant_log.size() - base, 2);
        check("t2_first", grant_log[base], 0);
        check("t2_second", grant_log[base+1], 1);
        check("t2_gap", grant_cyc[base+1] - grant_cyc[base], 3);
        tick();
        mem_resp = 1'b0;
        pipe_load = 3'b011;
        tick();
        pipe_load = '0;
        for (int c = 0; c < 40; c++) begin
            auto_cycle(2, 0);
            if (m_done[1:0] == 2'b11) break;
        end
        check("t2_round2", {grant_log[base+2][1:0], grant_log[base+3][1:0]}, 4'b0001);
        tick();
        mem_resp = 1'b0;
        pipe_load = 3'b011;
        port_read = '0;
        tick();
        pipe_load = '0;

        // Three stages pending continuously rotate 0,1,2,0.
        reset_dut();
        base = grant_log.size();
        for (int i = 0; i < N; i++) set_port(i, 1, 0, 32'h400 + 32'(i * 8), '0, '0);
        for (int c = 0; c < 40; c++) begin
            auto_cycle(1, 1);
            if (grant_log.size() >= base + 4) break;
        end
        check("t6_order", {grant_log[base][1:0], grant_log[base+1][1:0], grant_log[base+2][1:0], grant_log[base+3][1:0]},
              8'b00_01_10_00);
        check("t6_gap", grant_cyc[base+1] - grant_cyc[base], 2);
        for (int c = 0; c < 10; c++) begin
            if (!m_busy) break;
            auto_cycle(1, 1);
        end
        port_read = '0;
        mem_resp = 1'b0;
        pipe_load = '0;

        // Randomized stages, memory latency, pipe_load timing and occasional resets.
        reset_dut();
        for (int i = 0; i < N; i++) seen[i] = adv_cnt[i];
        for (int c = 0; c < 4000; c++) rand_cycle();
        rst = 1'b1;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
